// File: rtl/ram_access_ctrl.sv
// Dual-port write arbiter plus burst-read sequencer in front of a 16-entry
// halfword RAM. Writes and reads run independently and concurrently.
module ram_access_ctrl #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [1:0]  a_strb,
  input  logic [3:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_gnt,
  input  logic        b_req,
  input  logic [1:0]  b_strb,
  input  logic [3:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_gnt,
  output logic        ram_wr_en,
  output logic [1:0]  ram_wr_strb,
  output logic [3:0]  ram_waddr,
  output logic [31:0] ram_wdata,
  input  logic        rd_start,
  input  logic [3:0]  rd_addr,
  input  logic [4:0]  rd_len,
  output logic        rd_busy,
  output logic        ram_rd_en,
  output logic [3:0]  ram_raddr,
  input  logic [15:0] ram_rdata,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t;

  rd_state_t  state_q, state_d;
  logic       prio_b;   // 1: port B wins the next tie
  logic [4:0] rem_q;    // issues still to perform, including the current one
  logic [4:0] len_clamped;
  logic       rd_accept;

  // Combinational grant: single requester wins, ties go to the priority port
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (a_req && b_req) begin
        a_gnt = !prio_b;
        b_gnt = prio_b;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Round-robin pointer: after a grant the other port gets the next tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_b <= RR_INIT;
    end else if (a_gnt) begin
      prio_b <= 1'b1;
    end else if (b_gnt) begin
      prio_b <= 1'b0;
    end
  end

  // Write register stage; a zero-strobe grant is consumed without a write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr_en   <= 1'b0;
      ram_wr_strb <= '0;
      ram_waddr   <= '0;
      ram_wdata   <= '0;
    end else begin
      ram_wr_en <= (a_gnt && (a_strb != 2'b00)) || (b_gnt && (b_strb != 2'b00));
      if (a_gnt) begin
        ram_wr_strb <= a_strb;
        ram_waddr   <= a_addr;
        ram_wdata   <= a_data;
      end else if (b_gnt) begin
        ram_wr_strb <= b_strb;
        ram_waddr   <= b_addr;
        ram_wdata   <= b_data;
      end
    end
  end

  assign len_clamped = (rd_len > 5'd16) ? 5'd16 : rd_len;
  assign rd_accept   = rd_start && (rd_len != 5'd0);

  // Read FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_accept) state_d = ISSUE;
      ISSUE:   if (rem_q == 5'd1) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read FSM state register and registered RAM read controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ram_rd_en <= 1'b0;
      ram_raddr <= '0;
      rem_q     <= '0;
      rd_done   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_done <= (state_q == ISSUE) && (rem_q == 5'd1);
      case (state_q)
        IDLE: begin
          if (rd_accept) begin
            ram_raddr <= rd_addr;
            ram_rd_en <= 1'b1;
            rem_q     <= len_clamped;
          end
        end
        ISSUE: begin
          if (rem_q == 5'd1) begin
            ram_rd_en <= 1'b0;
            rem_q     <= '0;
          end else begin
            ram_raddr <= ram_raddr + 4'd1;
            rem_q     <= rem_q - 5'd1;
          end
        end
        default: ram_rd_en <= 1'b0;
      endcase
    end
  end

  // Read data qualifier tracks the RAM's one-cycle read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= ram_rd_en;
    end
  end

  assign rd_busy = (state_q != IDLE);
  assign rd_data = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized scoreboard bench for ram_access_ctrl with a behavioural
// arbiter/burst model and a ROM-style RAM responder.
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [1:0]  a_strb = '0, b_strb = '0;
  logic [3:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_gnt, b_gnt;
  logic        ram_wr_en;
  logic [1:0]  ram_wr_strb;
  logic [3:0]  ram_waddr;
  logic [31:0] ram_wdata;
  logic        rd_start = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [4:0]  rd_len = '0;
  logic        rd_busy, ram_rd_en, rd_valid, rd_done;
  logic [3:0]  ram_raddr;
  logic [15:0] ram_rdata = '0;
  logic [15:0] rd_data;

  ram_access_ctrl #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_strb(a_strb), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_strb(b_strb), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .ram_wr_en(ram_wr_en), .ram_wr_strb(ram_wr_strb), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_busy(rd_busy),
    .ram_rd_en(ram_rd_en), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] s; logic [3:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [15:0] d; logic last; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  int total = 0;
  int bad   = 0;

  // Model state
  bit          prio_b = 1'b0;
  int          busy_left = 0;
  bit          a_pend = 0, b_pend = 0;
  logic [1:0]  a_s, b_s;
  logic [3:0]  a_ad, b_ad;
  logic [31:0] a_d, b_d;
  bit          rs_go = 0;
  logic [3:0]  rs_addr = '0;
  logic [4:0]  rs_len = '0;

  function automatic logic [15:0] rom(input logic [3:0] a);
    return {a, ~a, a ^ 4'h9, 4'h6};
  endfunction

  // RAM responder: read data one cycle after the read enable
  always @(posedge clk) ram_rdata <= ram_rd_en ? rom(ram_raddr) : 16'hBEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes/beats whenever the DUT presents them
  always @(negedge clk) begin
    if (ram_wr_en) begin
      if (wq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_strb", ram_wr_strb, w.s);
        chk("wr_addr", ram_waddr, w.a);
        chk("wr_data", ram_wdata, w.d);
      end
    end
    if (rd_valid) begin
      if (rq.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        rd_t r;
        r = rq.pop_front();
        chk("rd_data", rd_data, r.d);
        chk("rd_done", rd_done, r.last);
      end
    end else begin
      chk("rd_data_idle", rd_data, 0);
      chk("rd_done_idle", rd_done, 0);
    end
  end

  // One clock of stimulus plus reference-model prediction
  task automatic cycle();
    bit accept, ga, gb;
    int len;
    @(negedge clk);
    chk("rd_busy", rd_busy, busy_left > 0);
    accept = rs_go && (busy_left == 0) && (rs_len != 0);
    if (busy_left > 0) busy_left--;
    a_req = a_pend; a_strb = a_s; a_addr = a_ad; a_data = a_d;
    b_req = b_pend; b_strb = b_s; b_addr = b_ad; b_data = b_d;
    rd_start = rs_go; rd_addr = rs_addr; rd_len = rs_len;
    if (accept) begin
      len = (rs_len > 16) ? 16 : int'(rs_len);
      for (int i = 0; i < len; i++) begin
        logic [3:0] ad;
        ad = rs_addr + 4'(i);
        rq.push_back('{d: rom(ad), last: (i == len - 1)});
      end
      busy_left = len + 1;
    end
    rs_go = 0;
    #1;
    ga = a_pend && (!b_pend || !prio_b);
    gb = b_pend && (!a_pend || prio_b);
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    if (ga) begin
      prio_b = 1;
      if (a_s != 2'b00) wq.push_back('{s: a_s, a: a_ad, d: a_d});
      a_pend = 0;
    end else if (gb) begin
      prio_b = 0;
      if (b_s != 2'b00) wq.push_back('{s: b_s, a: b_ad, d: b_d});
      b_pend = 0;
    end
  endtask

  task automatic set_a(input logic [1:0] s, input logic [3:0] ad, input logic [31:0] d);
    a_pend = 1; a_s = s; a_ad = ad; a_d = d;
  endtask

  task automatic set_b(input logic [1:0] s, input logic [3:0] ad, input logic [31:0] d);
    b_pend = 1; b_s = s; b_ad = ad; b_d = d;
  endtask

  task automatic check_reset_outputs();
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_wr_strb", ram_wr_strb, 0);
    chk("rst_waddr", ram_waddr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_raddr", ram_raddr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
  endtask

  initial begin
    a_s = '0; a_ad = '0; a_d = '0; b_s = '0; b_ad = '0; b_d = '0;
    a_req = 1; b_req = 1;
    #1;
    check_reset_outputs();
    a_req = 0; b_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Tie with RR_INIT=0: A then B
    set_a(2'b11, 4'd2, 32'h1111_2222);
    set_b(2'b11, 4'd5, 32'h3333_4444);
    cycle(); cycle(); cycle();

    // A held four cycles, B idle
    for (int i = 0; i < 4; i++) begin
      set_a(2'b01 + 2'(i % 3), 4'(i), $urandom);
      cycle();
    end

    // Zero-strobe request, then wrap-address full write
    set_a(2'b00, 4'd3, 32'hDEAD_0000); cycle();
    set_a(2'b11, 4'd15, 32'hCAFE_F00D); cycle();
    cycle();

    // Burst wrapping 14,15,0,1 with a start attempt while busy
    rs_go = 1; rs_addr = 4'd14; rs_len = 5'd4; cycle();
    cycle();
    rs_go = 1; rs_addr = 4'd7; rs_len = 5'd3; cycle();
    repeat (5) cycle();
    rs_go = 1; rs_addr = 4'd9; rs_len = 5'd0; cycle();
    repeat (3) cycle();

    // Randomized mix of writes and bursts
    for (int n = 0; n < 600; n++) begin
      if (!a_pend && ($urandom % 3 == 0)) set_a(2'($urandom), 4'($urandom), $urandom);
      if (!b_pend && ($urandom % 3 == 0)) set_b(2'($urandom), 4'($urandom), $urandom);
      if ($urandom % 6 == 0) begin
        rs_go = 1; rs_addr = 4'($urandom); rs_len = 5'($urandom_range(0, 20));
      end
      cycle();
    end
    repeat (20) cycle();

    // Reset during the second beat of an 8-beat burst
    rs_go = 1; rs_addr = 4'd3; rs_len = 5'd8; cycle();
    repeat (3) cycle();
    #1 rst = 1;
    #1 check_reset_outputs();
    rq.delete(); wq.delete();
    busy_left = 0; prio_b = 1'b0;
    @(posedge clk);
    #1 rst = 0;
    rs_go = 1; rs_addr = 4'd12; rs_len = 5'd20; cycle();
    repeat (25) cycle();

    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, initial round-robin pointer (0 = port A wins first tie, 1 = port B).
REQ-002 SHALL have one clock, with reset asynchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 a_req  input  1  port A write request, held until granted.
REQ-006 a_strb  input  2  port A halfword strobe (01 low, 10 high, 11 both).
REQ-007 a_addr  input  4  port A halfword address.
REQ-008 a_data  input  32  port A write data.
REQ-009 a_gnt  output  1  port A grant, combinational, one cycle per accepted request.
REQ-010 b_req, b_strb, b_addr, b_data, b_gnt SHALL have the same directions and widths as port A, for port B.
REQ-011 ram_wr_en  output  1  registered write enable to the RAM.
REQ-012 ram_wr_strb  output  2, ram_waddr  output  4, ram_wdata  output  32: registered write fields.
REQ-013 rd_start  input  1  single-cycle burst-read start pulse.
REQ-014 rd_addr  input  4, rd_len  input  5: burst start address and length (1..16).
REQ-015 rd_busy  output  1  burst in progress.
REQ-016 ram_rd_en  output  1, ram_raddr  output  4: registered RAM read controls.
REQ-017 ram_rdata  input  16  RAM read data, valid one cycle after ram_rd_en.
REQ-018 rd_data  output  16, rd_valid  output  1, rd_done  output  1: returned data, qualifier, and last-beat pulse.

Function
REQ-019 Write arbiter SHALL evaluate each cycle: only one req asserted -> grant it; both asserted -> grant the port not granted last; neither -> no grant.
REQ-020 Round-robin pointer SHALL update only on a grant, recording the granted port.
REQ-021 On a grant, the next cycle SHALL drive ram_wr_en=1 with the granted strb/addr/data; with no grant, ram_wr_en=0 and the fields hold their previous values.
REQ-022 A granted request with strb=00 SHALL be consumed (gnt=1) with ram_wr_en=0 in the following cycle.
REQ-023 Back-to-back grants SHALL sustain one write per cycle; a port holding req after its grant competes again in the next cycle.
REQ-024 Read FSM states SHALL be IDLE, ISSUE and DRAIN.
REQ-025 IDLE->ISSUE SHALL occur on rd_start with rd_len!=0: ram_raddr<=rd_addr, ram_rd_en<=1, remaining count<=rd_len.
REQ-026 In ISSUE, ram_raddr SHALL increment by 1 per cycle modulo 16 (15->0); after rd_len issues, ram_rd_en<=0 and the state moves to DRAIN.
REQ-027 DRAIN->IDLE SHALL occur after one cycle.
REQ-028 rd_busy SHALL be 1 in ISSUE and DRAIN.
REQ-029 rd_valid SHALL equal ram_rd_en delayed one cycle, and rd_data SHALL equal ram_rdata when rd_valid=1, else 0.
REQ-030 rd_done SHALL pulse for one cycle, coincident with the final rd_valid of the burst.
REQ-031 rd_start SHALL be ignored while rd_busy=1 or when rd_len=0.
REQ-032 rd_len values above 16 SHALL be treated as 16.
REQ-033 Reads and writes SHALL proceed concurrently with no forwarding: a same-cycle same-address read returns pre-write data.
REQ-034 A 2'b11 write at ram_waddr=15 SHALL be passed through unchanged; its upper halfword lands at address 0 (RAM wrap).

Reset
REQ-035 rst=1 SHALL asynchronously force: ram_wr_en, ram_wr_strb, ram_waddr, ram_wdata, ram_rd_en, ram_raddr, rd_valid and rd_done to 0; read FSM to IDLE; pointer to RR_INIT.
REQ-036 a_gnt and b_gnt SHALL be 0 while rst=1.
REQ-037 Reset asserted mid-burst SHALL abort the burst with no rd_done; after release the block accepts a new rd_start.

Verification
REQ-038 Simultaneous req, RR_INIT=0, a_addr=2/a_data=0x11112222, b_addr=5/b_data=0x33334444, strb 11 both -> gnt A cycle 1, B cycle 2; ram_wr_en high two consecutive cycles with A then B fields.
REQ-039 a_req held 4 cycles, b idle -> a_gnt 4 consecutive cycles, 4 writes.
REQ-040 rd_start, rd_addr=14, rd_len=4 -> ram_raddr 14,15,0,1; rd_valid 4 cycles starting one cycle after the first issue; rd_done with 4th beat; rd_busy 5 cycles.
REQ-041 rd_start during busy, and rd_start with rd_len=0 -> ignored, no change in FSM or outputs.
REQ-042 rst pulse at 2nd beat of a 8-beat burst -> all outputs 0 immediately; no rd_done; new burst after release completes normally.
REQ-043 strb=00 request -> gnt=1, ram_wr_en stays 0; write at addr 15 strb 11 passes ram_waddr=15 unchanged.
